// File: rtl/approx_adder_evaluator_if.sv
// Bundle between the approximate-adder evaluator and its host/adder side:
// operands out, approximate sum in, start/status and raw error accumulators.
interface approx_adder_evaluator_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic [WIDTH:0]         sum_in;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH:0]       total_cases;
  logic [2*WIDTH:0]       error_cases;
  logic [3*WIDTH:0]       total_ed;
  logic [4*WIDTH+1:0]     total_sq_ed;
  logic [WIDTH:0]         max_ed;

  modport master (
    input  start, sum_in,
    output op_a, op_b, busy, done,
    output total_cases, error_cases, total_ed, total_sq_ed, max_ed
  );

  modport slave (
    output start, sum_in,
    input  op_a, op_b, busy, done,
    input  total_cases, error_cases, total_ed, total_sq_ed, max_ed
  );
endinterface

// File: rtl/approx_adder_evaluator.sv
// Exhaustive on-chip sweep of a WIDTH-bit approximate adder; accumulates raw
// error-distance statistics against the exact sum in a two-stage pipeline.
module approx_adder_evaluator #(
  parameter int WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  approx_adder_evaluator_if.master bus
);
  localparam int CW = 2*WIDTH + 1;
  localparam int EW = 3*WIDTH + 1;
  localparam int SW = 4*WIDTH + 2;
  localparam int DW = WIDTH + 1;
  localparam int PW = 2*WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [DW-1:0]    r_s1_sum;
  logic [DW-1:0]    r_s1_exact;
  logic             r_s1_valid;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_total_cases;
  logic [CW-1:0]    r_error_cases;
  logic [EW-1:0]    r_total_ed;
  logic [SW-1:0]    r_total_sq_ed;
  logic [DW-1:0]    r_max_ed;

  logic             w_start_ok;
  logic             w_last_pair;
  logic [DW-1:0]    w_ed;
  logic [PW-1:0]    w_ed_ext;
  logic [PW-1:0]    w_ed_sq;

  function automatic logic [DW-1:0] f_abs_diff(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] d;
    if (x >= y) d = x - y;
    else        d = y - x;
    return d;
  endfunction

  assign w_start_ok  = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_pair = (&r_op_a) && (&r_op_b);
  assign w_ed        = f_abs_diff(r_s1_exact, r_s1_sum);
  assign w_ed_ext    = PW'(w_ed);
  assign w_ed_sq     = w_ed_ext * w_ed_ext;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) w_next_state = ST_RUN;
        else           w_next_state = r_state;
      end
      ST_RUN: begin
        if (w_last_pair) w_next_state = ST_DRAIN;
        else             w_next_state = ST_RUN;
      end
      ST_DRAIN: w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Status flags registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == ST_RUN) || (w_next_state == ST_DRAIN);
      r_done <= (w_next_state == ST_DONE);
    end
  end

  // Operand sweep (op_b inner loop) and stage-1 capture; operands hold on the last pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_s1_sum   <= '0;
      r_s1_exact <= '0;
      r_s1_valid <= 1'b0;
    end else if (w_start_ok) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_s1_sum   <= '0;
      r_s1_exact <= '0;
      r_s1_valid <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_s1_sum   <= bus.sum_in;
      r_s1_exact <= {1'b0, r_op_a} + {1'b0, r_op_b};
      r_s1_valid <= 1'b1;
      if (!w_last_pair) begin
        r_op_b <= r_op_b + WIDTH'(1'b1);
        if (&r_op_b) r_op_a <= r_op_a + WIDTH'(1'b1);
      end
    end else if (r_state == ST_DRAIN) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage-2 error accumulation; widths cover the all-maximum-ED worst case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total_cases <= '0;
      r_error_cases <= '0;
      r_total_ed    <= '0;
      r_total_sq_ed <= '0;
      r_max_ed      <= '0;
    end else if (w_start_ok) begin
      r_total_cases <= '0;
      r_error_cases <= '0;
      r_total_ed    <= '0;
      r_total_sq_ed <= '0;
      r_max_ed      <= '0;
    end else if (r_s1_valid) begin
      r_total_cases <= r_total_cases + CW'(1'b1);
      r_error_cases <= r_error_cases + CW'(w_ed != '0);
      r_total_ed    <= r_total_ed + EW'(w_ed);
      r_total_sq_ed <= r_total_sq_ed + SW'(w_ed_sq);
      if (w_ed > r_max_ed) r_max_ed <= w_ed;
    end
  end

  assign bus.op_a        = r_op_a;
  assign bus.op_b        = r_op_b;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.total_cases = r_total_cases;
  assign bus.error_cases = r_error_cases;
  assign bus.total_ed    = r_total_ed;
  assign bus.total_sq_ed = r_total_sq_ed;
  assign bus.max_ed      = r_max_ed;
endmodule

// File: tb/tb_approx_adder_evaluator.sv
// Directed sweeps of several adder models (including a random-error table) at
// WIDTH=4, checked against statistics recomputed from plain arithmetic.
module tb_approx_adder_evaluator;
  localparam int W  = 4;
  localparam int NP = 1 << (2*W);

  localparam int M_EXACT = 0;
  localparam int M_ZERO  = 1;
  localparam int M_LSB   = 2;
  localparam int M_OFF1  = 3;
  localparam int M_RAND  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   total = 0;
  int   bad = 0;
  int   cycles;
  logic [W:0] rnd_tbl [NP];

  longint e_tot, e_err, e_ed, e_sq, e_max;

  approx_adder_evaluator_if #(.WIDTH(W)) bus ();

  approx_adder_evaluator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The adder under test, selectable between several behaviours.
  always_comb begin
    case (mode)
      M_EXACT: bus.sum_in = {1'b0, bus.op_a} + {1'b0, bus.op_b};
      M_ZERO:  bus.sum_in = '0;
      M_LSB:   bus.sum_in = ({1'b0, bus.op_a} + {1'b0, bus.op_b}) | 5'd1;
      M_OFF1:  bus.sum_in = {1'b0, bus.op_a} + {1'b0, bus.op_b} + 5'd1;
      M_RAND:  bus.sum_in = rnd_tbl[{bus.op_a, bus.op_b}];
      default: bus.sum_in = '0;
    endcase
  end

  function automatic int adder_out(input int m, input int a, input int b);
    case (m)
      M_EXACT: return a + b;
      M_ZERO:  return 0;
      M_LSB:   return (a + b) | 1;
      M_OFF1:  return a + b + 1;
      M_RAND:  return int'(rnd_tbl[a*16 + b]);
      default: return 0;
    endcase
  endfunction

  task automatic model(input int m);
    e_tot = 0; e_err = 0; e_ed = 0; e_sq = 0; e_max = 0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        longint ex, s, ed;
        ex = a + b;
        s  = adder_out(m, a, b);
        ed = (ex > s) ? ex - s : s - ex;
        e_tot++;
        e_ed += ed;
        e_sq += ed * ed;
        if (ed != 0) e_err++;
        if (ed > e_max) e_max = ed;
      end
    end
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, ".total_cases"}, longint'(bus.total_cases), e_tot);
    check({tag, ".error_cases"}, longint'(bus.error_cases), e_err);
    check({tag, ".total_ed"},    longint'(bus.total_ed),    e_ed);
    check({tag, ".total_sq_ed"}, longint'(bus.total_sq_ed), e_sq);
    check({tag, ".max_ed"},      longint'(bus.max_ed),      e_max);
  endtask

  // Pulse start, then count edges until done; inj>0 re-pulses start mid-run.
  task automatic run_sweep(input string tag, input int inj, output int n);
    n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, ".busy_at_start"}, longint'(bus.busy), 1);
    check({tag, ".done_at_start"}, longint'(bus.done), 0);
    check({tag, ".cleared_at_start"}, longint'(bus.total_cases), 0);
    for (int i = 1; i <= NP + 100; i++) begin
      @(posedge clk);
      #1;
      bus.start = (i == inj);
      if (bus.done) begin
        n = i;
        break;
      end
    end
    bus.start = 1'b0;
    check({tag, ".cycles_to_done"}, longint'(n), longint'(NP + 1));
    check({tag, ".busy_in_done"}, longint'(bus.busy), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    mode      = M_EXACT;
    for (int i = 0; i < NP; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_tbl[i] = 5'($urandom_range(0, 31));
      else                           rnd_tbl[i] = 5'((i >> 4) + (i & 15));
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset.op_a", longint'(bus.op_a), 0);
    check("reset.busy", longint'(bus.busy), 0);
    check("reset.done", longint'(bus.done), 0);
    check("reset.total_cases", longint'(bus.total_cases), 0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = M_EXACT;
    model(M_EXACT);
    run_sweep("exact", 0, cycles);
    check_results("exact");
    check("exact.total_const", longint'(bus.total_cases), 256);
    check("exact.err_const", longint'(bus.error_cases), 0);

    mode = M_OFF1;
    model(M_OFF1);
    run_sweep("off1_midstart", 50, cycles);
    check_results("off1_midstart");
    check("off1.err_const", longint'(bus.error_cases), 256);
    check("off1.ed_const", longint'(bus.total_ed), 256);
    check("off1.max_const", longint'(bus.max_ed), 1);

    mode = M_LSB;
    model(M_LSB);
    run_sweep("lsb", 0, cycles);
    check_results("lsb");
    check("lsb.err_const", longint'(bus.error_cases), 128);

    mode = M_ZERO;
    model(M_ZERO);
    run_sweep("zero", 0, cycles);
    check_results("zero");
    check("zero.err_const", longint'(bus.error_cases), 255);
    check("zero.ed_const", longint'(bus.total_ed), 3840);
    check("zero.sq_const", longint'(bus.total_sq_ed), 68480);
    check("zero.max_const", longint'(bus.max_ed), 30);
    repeat (5) @(posedge clk);
    #1;
    check("zero.hold_op_a", longint'(bus.op_a), 15);
    check("zero.hold_op_b", longint'(bus.op_b), 15);
    check("zero.hold_done", longint'(bus.done), 1);
    check("zero.hold_ed", longint'(bus.total_ed), 3840);

    mode = M_EXACT;
    model(M_EXACT);
    run_sweep("restart_exact", 0, cycles);
    check_results("restart_exact");

    mode = M_ZERO;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.op_a", longint'(bus.op_a), 0);
    check("midreset.op_b", longint'(bus.op_b), 0);
    check("midreset.busy", longint'(bus.busy), 0);
    check("midreset.done", longint'(bus.done), 0);
    check("midreset.total_cases", longint'(bus.total_cases), 0);
    check("midreset.total_ed", longint'(bus.total_ed), 0);
    check("midreset.max_ed", longint'(bus.max_ed), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_after_reset.busy", longint'(bus.busy), 0);
    check("idle_after_reset.done", longint'(bus.done), 0);
    check("idle_after_reset.op_b", longint'(bus.op_b), 0);
    check("idle_after_reset.total_cases", longint'(bus.total_cases), 0);

    mode = M_RAND;
    model(M_RAND);
    run_sweep("random", 0, cycles);
    check_results("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
